// File: rtl/cluster_link_formatter.sv
// Buffers strobed cluster sets in a small FIFO and serialises each set onto a
// 32-bit ready/valid link as a 4-beat frame with a per-beat header nibble.
module cluster_link_formatter #(
  parameter int FIFO_DEPTH     = 4,
  parameter bit SUPPRESS_EMPTY = 1'b1
) (
  input  logic        clock4x,
  input  logic        global_reset_n,
  input  logic        clusters_valid,
  input  logic [13:0] cluster0,
  input  logic [13:0] cluster1,
  input  logic [13:0] cluster2,
  input  logic [13:0] cluster3,
  input  logic [13:0] cluster4,
  input  logic [13:0] cluster5,
  input  logic [13:0] cluster6,
  input  logic [13:0] cluster7,
  input  logic        overflow,
  input  logic        bc0,
  output logic [31:0] link_data,
  output logic        link_valid,
  input  logic        link_ready,
  output logic        fifo_full,
  output logic [15:0] drop_count
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [7:0][13:0] set_in;
  logic [113:0]     entry;
  logic             all_invalid;
  logic             set_empty;

  logic [113:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic             fifo_empty;
  logic             wr_attempt, push, pop;

  logic [0:0]       state;
  logic [1:0]       beat;
  logic [113:0]     frame;

  assign set_in = {cluster7, cluster6, cluster5, cluster4,
                   cluster3, cluster2, cluster1, cluster0};
  assign entry  = {bc0, overflow, set_in};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    all_invalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (set_in[i][10:9] != 2'b11) all_invalid = 1'b0;
    end
  end

  assign set_empty  = all_invalid && !overflow && !bc0;
  assign fifo_empty = (count == '0);

  // The frame register refills whenever it is (or is about to become) free.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (link_ready && beat == 2'd3));

  assign wr_attempt = clusters_valid && !(SUPPRESS_EMPTY && set_empty);
  assign push       = wr_attempt && (!fifo_full || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // NOTE: the storage array carries no reset; emptiness is defined by the
  // pointers and count alone, which keeps the array a plain RAM.
  always_ff @(posedge clock4x) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      fifo_full <= (count_next == DEPTH_C);
      if (wr_attempt && !push && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state <= IDLE;
      beat  <= '0;
      frame <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state <= SEND;
            beat  <= '0;
          end
        end
        SEND: begin
          if (link_ready) begin
            if (beat == 2'd3) begin
              beat <= '0;
              if (!pop) state <= IDLE;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) frame <= mem[rd_ptr];
    end
  end

  assign link_valid = (state == SEND);

  // Header: {first-beat flag, beat index, overflow on beat 0 / bc0 on beat 1}.
  always_comb begin
    link_data = '0;
    if (state == SEND) begin
      link_data[31]    = (beat == 2'd0);
      link_data[30:29] = beat;
      link_data[28]    = (beat == 2'd0) ? frame[112] :
                         (beat == 2'd1) ? frame[113] : 1'b0;
      link_data[27:0]  = frame[int'(beat) * 28 +: 28];
    end
  end

endmodule

// File: tb/tb_cluster_link_formatter.sv
// Self-checking bench for cluster_link_formatter: hand-made frame vectors,
// multi-cycle corner sequences and a random run against a queue-based model.
module tb_cluster_link_formatter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clusters_valid = 1'b0;
  logic [13:0] cl [8];
  logic        ovf = 1'b0;
  logic        b0 = 1'b0;
  logic [31:0] link_data;
  logic        link_valid;
  logic        link_ready = 1'b0;
  logic        fifo_full;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cluster_link_formatter #(.FIFO_DEPTH(DEPTH), .SUPPRESS_EMPTY(1'b1)) dut (
    .clock4x(clk), .global_reset_n(rst_n), .clusters_valid(clusters_valid),
    .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
    .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
    .overflow(ovf), .bc0(b0), .link_data(link_data), .link_valid(link_valid),
    .link_ready(link_ready), .fifo_full(fifo_full), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [7:0][13:0] c;
    logic             ovf;
    logic             bc0;
    logic [3:0][31:0] beats;
  } vec_t;

  vec_t vecs [4];

  // Reference model: a queue of stored sets plus the frame being sent.
  logic [113:0] mq [$];
  logic         m_have = 1'b0;
  logic [113:0] m_frame = '0;
  int           m_k = 0;
  int           m_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_beat(input logic [113:0] f, input int k);
    logic [31:0] d;
    logic [13:0] lo, hi;
    lo = f[14 * (2 * k) +: 14];
    hi = f[14 * (2 * k + 1) +: 14];
    d[31]    = (k == 0);
    d[30:29] = 2'(k);
    d[28]    = (k == 0) ? f[112] : (k == 1) ? f[113] : 1'b0;
    d[27:0]  = {hi, lo};
    return d;
  endfunction

  function automatic bit model_set_empty();
    int n_invalid = 0;
    for (int i = 0; i < 8; i++) if (cl[i][10:9] == 2'b11) n_invalid++;
    return (n_invalid == 8) && !ovf && !b0;
  endfunction

  task automatic model_step();
    logic [113:0] e;
    if (m_have && link_ready) begin
      if (m_k == 3) m_have = 1'b0;
      else m_k++;
    end
    if (!m_have && mq.size() > 0) begin
      m_frame = mq.pop_front();
      m_have  = 1'b1;
      m_k     = 0;
    end
    if (clusters_valid && !model_set_empty()) begin
      e = {b0, ovf, cl[7], cl[6], cl[5], cl[4], cl[3], cl[2], cl[1], cl[0]};
      if (mq.size() < DEPTH) mq.push_back(e);
      else if (m_drops < 65535) m_drops++;
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_have = 1'b0;
    m_k = 0;
    m_drops = 0;
  endtask

  // One clock: compare outputs with the model, then advance both at the edge.
  task automatic tick();
    check("link_valid", {31'b0, link_valid}, {31'b0, m_have});
    if (m_have) check("link_data", link_data, model_beat(m_frame, m_k));
    check("fifo_full", {31'b0, fifo_full}, {31'b0, mq.size() == DEPTH});
    check("drop_count", {16'b0, drop_count}, m_drops);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drive_set(input logic [7:0][13:0] c, input logic o, input logic b, input logic v);
    for (int i = 0; i < 8; i++) cl[i] = c[i];
    ovf = o;
    b0 = b;
    clusters_valid = v;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_link_valid", {31'b0, link_valid}, 32'd0);
    check("rst_link_data", link_data, 32'd0);
    check("rst_fifo_full", {31'b0, fifo_full}, 32'd0);
    check("rst_drop_count", {16'b0, drop_count}, 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic random_set();
    logic [7:0][13:0] c;
    bit make_empty;
    make_empty = ($urandom_range(3, 0) == 0);
    for (int i = 0; i < 8; i++) begin
      c[i] = 14'($urandom);
      if (make_empty || $urandom_range(1, 0) == 1) c[i][10:9] = 2'b11;
    end
    drive_set(c, make_empty ? 1'b0 : ($urandom_range(3, 0) == 0),
                 make_empty ? 1'b0 : ($urandom_range(3, 0) == 0),
                 ($urandom_range(2, 0) == 0));
  endtask

  initial begin
    logic [7:0][13:0] empty_c;
    logic [7:0][13:0] c;
    int frames;

    empty_c = {8{14'h07FE}};

    vecs[0].c = {{6{14'h07FE}}, 14'h0801, 14'h0005};
    vecs[0].ovf = 1'b0; vecs[0].bc0 = 1'b1;
    vecs[0].beats[0] = {4'b1000, 14'h0801, 14'h0005};
    vecs[0].beats[1] = {4'b0011, 14'h07FE, 14'h07FE};
    vecs[0].beats[2] = {4'b0100, 14'h07FE, 14'h07FE};
    vecs[0].beats[3] = {4'b0110, 14'h07FE, 14'h07FE};

    vecs[1].c = {14'h3817, 14'h3016, 14'h2815, 14'h2014,
                 14'h1813, 14'h1012, 14'h0811, 14'h0010};
    vecs[1].ovf = 1'b1; vecs[1].bc0 = 1'b0;
    vecs[1].beats[0] = {4'b1001, 14'h0811, 14'h0010};
    vecs[1].beats[1] = {4'b0010, 14'h1813, 14'h1012};
    vecs[1].beats[2] = {4'b0100, 14'h2815, 14'h2014};
    vecs[1].beats[3] = {4'b0110, 14'h3817, 14'h3016};

    vecs[2].c = {8{14'h07FE}};
    vecs[2].ovf = 1'b1; vecs[2].bc0 = 1'b0;
    vecs[2].beats[0] = {4'b1001, 14'h07FE, 14'h07FE};
    vecs[2].beats[1] = {4'b0010, 14'h07FE, 14'h07FE};
    vecs[2].beats[2] = {4'b0100, 14'h07FE, 14'h07FE};
    vecs[2].beats[3] = {4'b0110, 14'h07FE, 14'h07FE};

    vecs[3].c = {14'h1E00, {7{14'h07FE}}};
    vecs[3].ovf = 1'b0; vecs[3].bc0 = 1'b1;
    vecs[3].beats[0] = {4'b1000, 14'h07FE, 14'h07FE};
    vecs[3].beats[1] = {4'b0011, 14'h07FE, 14'h07FE};
    vecs[3].beats[2] = {4'b0100, 14'h07FE, 14'h07FE};
    vecs[3].beats[3] = {4'b0110, 14'h1E00, 14'h07FE};

    drive_set(empty_c, 1'b0, 1'b0, 1'b0);
    #2;
    apply_reset();
    tick();

    // Frame format and two-cycle latency.
    link_ready = 1'b1;
    foreach (vecs[v]) begin
      drive_set(vecs[v].c, vecs[v].ovf, vecs[v].bc0, 1'b1);
      tick();
      clusters_valid = 1'b0;
      check($sformatf("vec%0d_n1_idle", v), {31'b0, link_valid}, 32'd0);
      tick();
      check($sformatf("vec%0d_n2_valid", v), {31'b0, link_valid}, 32'd1);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("vec%0d_beat%0d", v, k), link_data, vecs[v].beats[k]);
        tick();
      end
      check($sformatf("vec%0d_done", v), {31'b0, link_valid}, 32'd0);
    end

    // Empty set is suppressed and not counted.
    drive_set(empty_c, 1'b0, 1'b0, 1'b1);
    tick();
    clusters_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("empty_no_valid", {31'b0, link_valid}, 32'd0);
      tick();
    end
    check("empty_no_drop", {16'b0, drop_count}, 32'd0);

    // Backpressure held for 10 cycles on beat 1.
    drive_set(vecs[0].c, vecs[0].ovf, vecs[0].bc0, 1'b1);
    tick();
    clusters_valid = 1'b0;
    tick();
    tick();
    link_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_beat1", link_data, vecs[0].beats[1]);
      tick();
    end
    link_ready = 1'b1;
    tick();
    check("bp_then_beat2", link_data, vecs[0].beats[2]);
    tick();
    tick();

    // Six strobes while stalled: four stored, one in the frame, one dropped.
    link_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      c = vecs[1].c;
      c[0] = 14'(16'h0100 + s);
      drive_set(c, 1'b0, 1'b0, 1'b1);
      tick();
    end
    clusters_valid = 1'b0;
    check("ovf_drop_count", {16'b0, drop_count}, 32'd1);
    check("ovf_fifo_full", {31'b0, fifo_full}, 32'd1);
    link_ready = 1'b1;
    frames = 0;
    for (int i = 0; i < 30; i++) begin
      if (link_valid && link_ready && link_data[31]) frames++;
      tick();
    end
    check("ovf_frames", frames, 32'd5);

    // Back-to-back strobes every 4 cycles stream without bubbles.
    for (int i = 0; i < 26; i++) begin
      c = vecs[1].c;
      c[1] = 14'(16'h0200 + i);
      drive_set(c, 1'b1, 1'b0, (i % 4 == 0) && (i < 24));
      if (i >= 2) begin
        check("b2b_valid", {31'b0, link_valid}, 32'd1);
        check("b2b_hdr3", {31'b0, link_data[31]}, {31'b0, ((i - 2) % 4 == 0)});
      end
      tick();
    end
    clusters_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Randomised run against the model.
    for (int i = 0; i < 1500; i++) begin
      random_set();
      link_ready = ($urandom_range(9, 0) < 7);
      tick();
    end
    clusters_valid = 1'b0;
    link_ready = 1'b1;
    for (int i = 0; i < 30; i++) tick();

    // Reset during beat 2 abandons the frame.
    apply_reset();
    drive_set(vecs[0].c, vecs[0].ovf, vecs[0].bc0, 1'b1);
    tick();
    clusters_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rst_mid_beat2", link_data, vecs[0].beats[2]);
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      check("rst_no_resume", {31'b0, link_valid}, 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cluster_link_formatter.md
CLUSTER_LINK_FORMATTER -- requirements
Module: cluster_link_formatter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set cluster-set FIFO depth; power of two, 2..16.
REQ-002 Parameter SUPPRESS_EMPTY, default 1, SHALL enable dropping of empty cluster sets (1 = suppress).
REQ-003 clock4x  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 global_reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 clusters_valid  in  1  SHALL be a one-cycle strobe marking the cycle in which cluster0..7, overflow and bc0 are valid.
REQ-006 cluster0..cluster7  in  14 each  SHALL each carry {cnt[2:0], adr[10:0]}; adr[10:9]==2'b11 marks an invalid cluster.
REQ-007 overflow  in  1  SHALL be the packer overflow flag for the strobed set.
REQ-008 bc0  in  1  SHALL be the bunch-crossing-zero marker for the strobed set.
REQ-009 link_data  out  32  SHALL be the current frame beat.
REQ-010 link_valid  out  1  SHALL be high while link_data holds a beat not yet accepted.
REQ-011 link_ready  in  1  SHALL be the downstream accept; a beat transfers on link_valid & link_ready.
REQ-012 fifo_full  out  1  SHALL be high when the FIFO holds FIFO_DEPTH entries.
REQ-013 drop_count  out  16  SHALL count cluster sets lost to a full FIFO.

Function
REQ-014 Set is "empty" when all 8 clusters are invalid and overflow==0 and bc0==0.
REQ-015 On clusters_valid, an empty set with SUPPRESS_EMPTY=1 SHALL NOT be written and SHALL NOT increment drop_count.
REQ-016 Otherwise the 114-bit entry {bc0, overflow, cluster7..cluster0} SHALL be written at the end of that cycle if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-017 A write attempt that is refused SHALL increment drop_count by 1, saturating at 16'hFFFF.
REQ-018 Each entry SHALL be transmitted as 4 beats, k = 0..3: link_data = {hdr[3:0], cluster[2k+1], cluster[2k]}.
REQ-019 hdr[3] SHALL be 1 only on beat 0; hdr[2:1] SHALL be k; hdr[0] SHALL be overflow on beat 0, bc0 on beat 1, and 0 on beats 2 and 3.
REQ-020 The FSM SHALL have states IDLE and SEND.
REQ-021 IDLE: when the FIFO is non-empty, pop into the frame register, set beat=0 and go to SEND; link_valid=0 while in IDLE.
REQ-022 SEND: link_valid=1; link_data and beat SHALL be held stable while link_ready==0.
REQ-023 SEND: on acceptance of beats 0..2, beat SHALL increment.
REQ-024 SEND: on acceptance of beat 3, pop the next entry and restart at beat 0 if the FIFO is non-empty (no idle cycle); otherwise return to IDLE.
REQ-025 Latency: a strobe in cycle N, with the FIFO empty, the FSM in IDLE and a non-empty set, SHALL produce link_valid=1 with beat 0 in cycle N+2.
REQ-026 With link_ready held high, throughput SHALL be 4 cycles per entry, with no bubbles between frames.
REQ-027 fifo_full SHALL be registered, reflecting the FIFO occupancy after the current edge; read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-028 On global_reset_n low, asynchronously: FIFO empty, FSM IDLE, beat=0, link_valid=0, link_data=0, fifo_full=0, drop_count=0.
REQ-029 A frame in progress when reset asserts SHALL be abandoned and SHALL NOT be resumed after release.
REQ-030 No FIFO write, pop or count SHALL occur in any cycle while global_reset_n is low.

Verification
REQ-031 Single set: cluster0=14'h0005, cluster1=14'h0801, others 14'h07FE, overflow=0, bc0=1, link_ready=1 -> 4 beats from cycle N+2.
- Beat 0 = {4'b1000, 14'h07FE... cluster1, cluster0} = {4'b1000, 14'h0801, 14'h0005}.
- Beat 1 hdr = 4'b0011.
- Beats 2 and 3 hdr = 4'b0100 and 4'b0110.
REQ-032 Empty set (all clusters 14'h07FE, overflow=0, bc0=0) with SUPPRESS_EMPTY=1 -> link_valid stays 0; drop_count stays 0.
REQ-033 Backpressure: link_ready=0 for 10 cycles during beat 1 -> link_data is stable for those 10 cycles; beat 2 follows the cycle after link_ready returns to 1.
REQ-034 Overflow handling, link_ready=0, 6 non-empty strobes with FIFO_DEPTH=4:
- The FSM pops one set into the frame register, so 4 sets are stored and 1 is dropped.
- Result: drop_count=1, fifo_full=1.
- After releasing link_ready, exactly 5 frames are emitted, in order.
REQ-035 Back-to-back: strobes every 4 cycles with link_ready=1 -> continuous link_valid; hdr[3] every 4th cycle; drop_count=0.
REQ-036 Reset during beat 2 -> link_valid=0 immediately; after release with the FIFO empty, no beat is emitted.
